// File: rtl/sd_pkg.sv
// Shared SD-bus definitions: CRC7 polynomial, response frame layout,
// command indices and the response receiver state encoding.
package sd_pkg;

  localparam logic [6:0] SD_CRC7_POLY = 7'h09;
  localparam int         SD_FRAME_W   = 48;

  localparam int SD_T_BIT   = 46;
  localparam int SD_IDX_HI  = 45;
  localparam int SD_IDX_LO  = 40;
  localparam int SD_ARG_HI  = 39;
  localparam int SD_ARG_LO  = 8;
  localparam int SD_CRC_HI  = 7;
  localparam int SD_CRC_LO  = 1;
  localparam int SD_END_BIT = 0;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RECV,
    ST_DONE
  } rx_state_t;

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial SD CRC7 (x^7 + x^3 + 1), MSB first. Clear has priority over enable.
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic w_fb;

  assign w_fb = o_crc[6] ^ i_bit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_crc <= 7'h00;
    end else if (i_clear) begin
      o_crc <= 7'h00;
    end else if (i_enable) begin
      o_crc <= {o_crc[5:0], 1'b0} ^ (w_fb ? SD_CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line 48-bit response receiver: Ncr start-bit hunt, deserialise,
// CRC7 and framing check, field hand-off to the command FSM.
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sd_clk_rise,
  input  logic        i_cmd_in,
  input  logic        i_arm,
  input  logic        i_abort,
  input  logic        i_crc_check,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [5:0]  o_resp_index,
  output logic [31:0] o_resp_arg,
  output logic [6:0]  o_resp_crc,
  output logic        o_crc_err,
  output logic        o_frame_err,
  output logic        o_timeout
);

  localparam int NCR_W = $clog2(NCR_MAX) + 1;

  rx_state_t         r_state;
  logic [NCR_W-1:0]  r_ncr_cnt;
  logic [5:0]        r_bit_cnt;
  logic [45:0]       r_sr;
  logic              r_crc_check;

  logic [46:0]       w_frame;
  logic [6:0]        w_crc;
  logic              w_crc_clr;
  logic              w_crc_en;

  // The start bit is shifted out by the end of the frame; only bits 46..0 are kept.
  assign w_frame   = {r_sr, i_cmd_in};
  assign w_crc_clr = (r_state == ST_IDLE) && i_arm && !i_abort;
  // CRC covers frame bits 47..8; in RECV the incoming bit index is r_bit_cnt-1.
  assign w_crc_en  = i_sd_clk_rise &&
                     (((r_state == ST_WAIT_START) && !i_cmd_in) ||
                      ((r_state == ST_RECV) && (r_bit_cnt >= 6'(SD_ARG_LO + 1))));

  sd_crc7_serial u_crc7 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_crc_clr),
    .i_enable (w_crc_en),
    .i_bit    (i_cmd_in),
    .o_crc    (w_crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_ncr_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sr         <= '0;
      r_crc_check  <= 1'b0;
      o_busy       <= 1'b0;
      o_resp_valid <= 1'b0;
      o_resp_index <= '0;
      o_resp_arg   <= '0;
      o_resp_crc   <= '0;
      o_crc_err    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_timeout    <= 1'b0;
    end else if (i_abort) begin
      r_state      <= ST_IDLE;
      o_busy       <= 1'b0;
      o_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_resp_valid <= 1'b0;
          if (i_arm) begin
            r_state     <= ST_WAIT_START;
            r_ncr_cnt   <= '0;
            r_crc_check <= i_crc_check;
            o_crc_err   <= 1'b0;
            o_frame_err <= 1'b0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b1;
          end
        end
        ST_WAIT_START: begin
          if (i_sd_clk_rise) begin
            if (!i_cmd_in) begin
              r_state   <= ST_RECV;
              r_sr      <= w_frame[45:0];
              r_bit_cnt <= 6'(SD_FRAME_W - 1);
            end else if (r_ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
              r_state   <= ST_IDLE;
              o_timeout <= 1'b1;
              o_busy    <= 1'b0;
            end else begin
              r_ncr_cnt <= r_ncr_cnt + 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (i_sd_clk_rise) begin
            r_sr      <= w_frame[45:0];
            r_bit_cnt <= r_bit_cnt - 1'b1;
            // Registering the fields on the end-bit strobe makes them valid during DONE.
            if (r_bit_cnt == 6'd1) begin
              r_state      <= ST_DONE;
              o_resp_valid <= 1'b1;
              o_busy       <= 1'b0;
              o_resp_index <= w_frame[SD_IDX_HI:SD_IDX_LO];
              o_resp_arg   <= w_frame[SD_ARG_HI:SD_ARG_LO];
              o_resp_crc   <= w_frame[SD_CRC_HI:SD_CRC_LO];
              o_crc_err    <= r_crc_check && (w_frame[SD_CRC_HI:SD_CRC_LO] != w_crc);
              o_frame_err  <= w_frame[SD_T_BIT] | ~w_frame[SD_END_BIT];
            end
          end
        end
        ST_DONE: begin
          o_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed bench for sd_cmd_resp_rx with an expected-response scoreboard
// and an independent CRC7 reference.
module tb_sd_cmd_resp_rx;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_sd_clk_rise = 1'b0;
  logic        i_cmd_in = 1'b1;
  logic        i_arm = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_crc_check = 1'b0;
  logic        o_busy;
  logic        o_resp_valid;
  logic [5:0]  o_resp_index;
  logic [31:0] o_resp_arg;
  logic [6:0]  o_resp_crc;
  logic        o_crc_err;
  logic        o_frame_err;
  logic        o_timeout;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        crc_err;
    logic        frame_err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  logic last_cc = 1'b1;

  sd_cmd_resp_rx dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_sd_clk_rise (i_sd_clk_rise),
    .i_cmd_in      (i_cmd_in),
    .i_arm         (i_arm),
    .i_abort       (i_abort),
    .i_crc_check   (i_crc_check),
    .o_busy        (o_busy),
    .o_resp_valid  (o_resp_valid),
    .o_resp_index  (o_resp_index),
    .o_resp_arg    (o_resp_arg),
    .o_resp_crc    (o_resp_crc),
    .o_crc_err     (o_crc_err),
    .o_frame_err   (o_frame_err),
    .o_timeout     (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_resp_valid) n_valid++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c = 7'h00;
    logic       fb;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic b);
    i_cmd_in      = b;
    i_sd_clk_rise = 1'b1;
    @(posedge i_clk); #1;
    i_sd_clk_rise = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic arm(input logic cc);
    i_crc_check = cc;
    last_cc     = cc;
    i_arm       = 1'b1;
    @(posedge i_clk); #1;
    i_arm       = 1'b0;
    i_crc_check = 1'b0;
    chk("busy_after_arm", 64'(o_busy), 64'd1);
  endtask

  task automatic send_frame(input logic [47:0] f);
    exp_t e;
    e.idx       = f[45:40];
    e.arg       = f[39:8];
    e.crc       = f[7:1];
    e.crc_err   = last_cc && (crc7(f[47:8]) != f[7:1]);
    e.frame_err = f[46] | ~f[0];
    sb_q.push_back(e);
    for (int i = 47; i >= 1; i--) strobe(f[i]);
    i_cmd_in      = f[0];
    i_sd_clk_rise = 1'b1;
    @(posedge i_clk); #1;
    i_sd_clk_rise = 1'b0;
    chk("valid_latency", 64'(o_resp_valid), 64'd1);
    chk("busy_at_valid", 64'(o_busy), 64'd0);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_index", 64'(o_resp_index), 64'(e.idx));
      chk("sb_arg", 64'(o_resp_arg), 64'(e.arg));
      chk("sb_crc", 64'(o_resp_crc), 64'(e.crc));
      chk("sb_crc_err", 64'(o_crc_err), 64'(e.crc_err));
      chk("sb_frame_err", 64'(o_frame_err), 64'(e.frame_err));
    end
    @(posedge i_clk); #1;
    chk("valid_one_cycle", 64'(o_resp_valid), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_valid"}, 64'(o_resp_valid), 64'd0);
    chk({tag, "_index"}, 64'(o_resp_index), 64'd0);
    chk({tag, "_arg"},   64'(o_resp_arg), 64'd0);
    chk({tag, "_crc"},   64'(o_resp_crc), 64'd0);
    chk({tag, "_crcerr"}, 64'(o_crc_err), 64'd0);
    chk({tag, "_frmerr"}, 64'(o_frame_err), 64'd0);
    chk({tag, "_tmo"},   64'(o_timeout), 64'd0);
  endtask

  initial begin
    logic [47:0] r7, r7_bad, host, host_noend, r3;
    int          nv;

    r7         = {8'h08, 32'h0000_01AA, crc7({8'h08, 32'h0000_01AA}), 1'b1};
    r7_bad     = r7 ^ (48'h1 << 11);
    host       = 48'h48_0000_01AA_87;
    host_noend = 48'h48_0000_01AA_86;
    r3         = 48'h3F_80FF_8000_FF;

    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Timeout after 64 idle strobes
    nv = n_valid;
    arm(1'b1);
    for (int i = 0; i < 63; i++) strobe(1'b1);
    chk("tmo_before_64", 64'(o_timeout), 64'd0);
    chk("busy_before_64", 64'(o_busy), 64'd1);
    strobe(1'b1);
    chk("tmo_at_64", 64'(o_timeout), 64'd1);
    chk("busy_after_tmo", 64'(o_busy), 64'd0);
    chk("tmo_no_valid", 64'(n_valid), 64'(nv));

    // R7 with 5 idle strobes of Ncr
    arm(1'b1);
    chk("arm_clears_tmo", 64'(o_timeout), 64'd0);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    send_frame(r7);
    chk("r7_index", 64'(o_resp_index), 64'(sd_pkg::CMD8));
    chk("r7_arg", 64'(o_resp_arg), 64'h1AA);
    chk("r7_crc_err", 64'(o_crc_err), 64'd0);

    // Corrupted argument bit 3
    arm(1'b1);
    send_frame(r7_bad);
    chk("bad_arg", 64'(o_resp_arg), 64'h1A2);
    chk("bad_crc_err", 64'(o_crc_err), 64'd1);
    chk("bad_frame_err", 64'(o_frame_err), 64'd0);
    chk("crc_err_sticky", 64'(o_crc_err), 64'd1);

    // Host-format CMD8 frame: T bit set, CRC correct
    arm(1'b1);
    chk("arm_clears_crc_err", 64'(o_crc_err), 64'd0);
    send_frame(host);
    chk("host_frame_err", 64'(o_frame_err), 64'd1);
    chk("host_crc_err", 64'(o_crc_err), 64'd0);
    chk("host_crc", 64'(o_resp_crc), 64'h43);
    arm(1'b1);
    send_frame(host_noend);
    chk("noend_frame_err", 64'(o_frame_err), 64'd1);

    // R3 with CRC check disabled
    arm(1'b0);
    send_frame(r3);
    chk("r3_arg", 64'(o_resp_arg), 64'h80FF8000);
    chk("r3_crc", 64'(o_resp_crc), 64'h7F);
    chk("r3_crc_err", 64'(o_crc_err), 64'd0);
    chk("r3_frame_err", 64'(o_frame_err), 64'd0);

    // Abort mid-frame, then a clean frame
    nv = n_valid;
    arm(1'b1);
    for (int i = 47; i >= 28; i--) strobe(r7[i]);
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'd0);
    for (int i = 27; i >= 0; i--) strobe(r7[i]);
    chk("abort_no_valid", 64'(n_valid), 64'(nv));

    i_arm   = 1'b1;
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_arm   = 1'b0;
    i_abort = 1'b0;
    chk("abort_beats_arm", 64'(o_busy), 64'd0);

    arm(1'b1);
    send_frame(r7);
    chk("post_abort_arg", 64'(o_resp_arg), 64'h1AA);

    // Reset mid-frame
    arm(1'b1);
    for (int i = 47; i >= 28; i--) strobe(r7[i]);
    i_rst_n = 1'b0;
    #2;
    chk_all_zero("midrst");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    arm(1'b1);
    send_frame(r7);
    chk("post_rst_index", 64'(o_resp_index), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
